// File: rtl/bus_host_arbiter.sv
// Round-robin multi-host arbiter onto one req/gnt/rvalid device port, with an in-order FIFO
// of host IDs that routes each response back to its requester. Define BUS_ARB_FIXED_PRIO_EN for fixed priority.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic [NrHosts-1:0]      host_req_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]      host_err_o,

  output logic                    dev_req_o,
  input  logic                    dev_gnt_i,
  output logic [AddressWidth-1:0] dev_addr_o,
  output logic                    dev_we_o,
  output logic [DataWidth/8-1:0]  dev_be_o,
  output logic [DataWidth-1:0]    dev_wdata_o,
  input  logic                    dev_rvalid_i,
  input  logic [DataWidth-1:0]    dev_rdata_i,
  input  logic                    dev_err_i
);

  localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int IdxW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  localparam logic [IdW-1:0]  IdLast  = IdW'(NrHosts - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic            lock_vld_q, lock_vld_d;
  logic [IdW-1:0]  lock_id_q, lock_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [IdW-1:0]  fifo_d [MaxOutstanding];

  logic            rr_found;
  logic [IdW-1:0]  rr_winner;
  logic [IdW-1:0]  cand;
  logic [IdW-1:0]  winner;
  logic [IdW-1:0]  head_id;
  logic            fifo_full;
  logic            dev_req;
  logic            accept;
  logic            stall;
  logic            pop;

  // Walk the hosts starting at the priority pointer; the first requester found wins.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = ptr_q;
    for (int k = 0; k < NrHosts; k++) begin
      if (!rr_found && host_req_i[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
      cand = (cand == IdLast) ? '0 : cand + 1'b1;
    end
  end

  assign winner    = lock_vld_q ? lock_id_q : rr_winner;
  assign fifo_full = (cnt_q == CntMax);
  assign dev_req   = (rr_found | lock_vld_q) & ~fifo_full;
  assign accept    = dev_req & dev_gnt_i;
  assign stall     = dev_req & ~dev_gnt_i;
  assign head_id   = fifo_q[rd_ptr_q];
  assign pop       = dev_rvalid_i & (cnt_q != '0);

  assign dev_req_o   = dev_req;
  assign dev_addr_o  = dev_req ? host_addr_i[winner]  : '0;
  assign dev_we_o    = dev_req ? host_we_i[winner]    : 1'b0;
  assign dev_be_o    = dev_req ? host_be_i[winner]    : '0;
  assign dev_wdata_o = dev_req ? host_wdata_i[winner] : '0;

  for (genvar g = 0; g < NrHosts; g++) begin : g_host
    assign host_gnt_o[g]    = accept & (winner == IdW'(g));
    assign host_rvalid_o[g] = pop & (head_id == IdW'(g));
    assign host_err_o[g]    = pop & dev_err_i & (head_id == IdW'(g));
    assign host_rdata_o[g]  = dev_rdata_i;
  end

  // A stalled request is locked so the presented host cannot change mid-handshake.
  always_comb begin
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (accept) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      ptr_d      = '0;
`else
      ptr_d      = (winner == IdLast) ? '0 : winner + 1'b1;
`endif
      lock_vld_d = 1'b0;
    end else if (stall) begin
      lock_vld_d = 1'b1;
      lock_id_d  = winner;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d         = (wr_ptr_q == IdxLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == IdxLast) ? '0 : rd_ptr_q + 1'b1;
    end
    if (accept && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule
